l2_cache_wb: RTL and testbench

Parametrised set-associative write-back L2 cache with true-LRU replacement, dirty-victim writeback and a full-cache flush command. It sits between the L1 cache and main memory, exchanging whole blocks on both sides. Unlike the previous write-through L2, memory is written only on eviction or flush.

---
 rtl/l2_cache_pkg.sv | 36 +++
 rtl/l2_lru.sv | 43 ++++
 rtl/l2_cache_wb.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_l2_cache_wb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the write-back L2 cache.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package l2_cache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND,
        ST_FLUSH
    } state_t;

    // Word-offset field width inside a block
    function automatic int calc_offset_w(input int block_words);
        return $clog2(block_words);
    endfunction

    // Set-index field width
    function automatic int calc_index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag field width: whatever address bits remain above offset and index
    function automatic int calc_tag_w(input int addr_width, input int block_words, input int num_sets);
        return addr_width - $clog2(block_words) - $clog2(num_sets);
    endfunction

    // Way-number / LRU age width
    function automatic int calc_way_w(input int num_ways);
        return $clog2(num_ways);
    endfunction

endpackage

// File: rtl/l2_lru.sv
// True-LRU age update and victim choice for the one set currently being addressed.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit ages_nxt.
module l2_lru
    import l2_cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W   = calc_way_w(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages,
    input  logic [NUM_WAYS-1:0]            valid,
    input  logic [WAY_W-1:0]               touch_way,
    output logic [NUM_WAYS-1:0][WAY_W-1:0] ages_nxt,
    output logic [WAY_W-1:0]               victim
);

    // Touched way becomes youngest; every way younger than it ages by one
    always_comb begin
        ages_nxt = ages;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (ages[w] < ages[touch_way]) begin
                ages_nxt[w] = ages[w] + 1'b1;
            end
        end
        ages_nxt[touch_way] = '0;
    end

    // Lowest-index invalid way wins; with a full set the oldest way is evicted
    always_comb begin
        victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (ages[w] == WAY_W'(NUM_WAYS - 1)) begin
                victim = WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/l2_cache_wb.sv
// Set-associative write-back L2 with true-LRU, dirty-victim writeback and full flush.
// Latency: hit 2 cycles request-to-ready; misses add writeback/fill memory handshakes.
// Backpressure: one request at a time; L1 strobes are ignored outside IDLE, memory strobes hold until mem_ready.
module l2_cache_wb
    import l2_cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int BLOCK_WORDS = 32,
    parameter int NUM_SETS    = 4,
    parameter int NUM_WAYS    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDR_WIDTH-1:0]             l1_cache_addr,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_cache_data_in,
    input  logic                              l1_cache_read,
    input  logic                              l1_cache_write,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_block_data_out,
    output logic                              l1_block_valid,
    output logic                              l1_cache_ready,
    output logic                              l1_cache_hit,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_out,
    output logic                              mem_read,
    output logic                              mem_write,
    input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_block,
    input  logic                              mem_ready
);

    localparam int OFFSET_W = calc_offset_w(BLOCK_WORDS);
    localparam int INDEX_W  = calc_index_w(NUM_SETS);
    localparam int TAG_W    = calc_tag_w(ADDR_WIDTH, BLOCK_WORDS, NUM_SETS);
    localparam int WAY_W    = calc_way_w(NUM_WAYS);
    localparam int BLK_W    = BLOCK_WORDS * DATA_WIDTH;

    // Line storage
    logic [TAG_W-1:0]               tag_q   [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0]               data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]            dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0][WAY_W-1:0] age_q   [NUM_SETS];

    // Registered request and controller context
    state_t                         state_q;
    logic [TAG_W+INDEX_W-1:0]       req_blk_q;
    logic [BLK_W-1:0]               req_data_q;
    logic                           req_wr_q;
    logic                           hit_q;
    logic [WAY_W-1:0]               vict_q;
    logic [WAY_W-1:0]               resp_way_q;
    logic [INDEX_W-1:0]             fl_set_q;
    logic [WAY_W-1:0]               fl_way_q;

    logic [INDEX_W-1:0]             req_idx;
    logic [TAG_W-1:0]               req_tag;
    logic                           hit;
    logic [WAY_W-1:0]               hit_way;
    logic [WAY_W-1:0]               victim;
    logic                           vict_dirty;
    logic [NUM_WAYS-1:0][WAY_W-1:0] ages_nxt;
    logic                           lru_touch;
    logic [WAY_W-1:0]               touch_way;
    logic                           data_we;
    logic [WAY_W-1:0]               data_way;
    logic [BLK_W-1:0]               data_wdat;
    logic                           fl_line_dirty;
    logic                           fl_adv;
    logic                           unused_offset_bits;

    // Word offset within the block never selects anything: whole blocks move
    assign unused_offset_bits = ^l1_cache_addr[OFFSET_W-1:0];

    assign req_idx       = req_blk_q[INDEX_W-1:0];
    assign req_tag       = req_blk_q[INDEX_W +: TAG_W];
    assign vict_dirty    = valid_q[req_idx][victim] && dirty_q[req_idx][victim];
    assign fl_line_dirty = valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];
    // Flush pointer moves on after a clean line or a finished writeback
    assign fl_adv        = (state_q == ST_FLUSH) && (mem_write ? mem_ready : !fl_line_dirty);

    l2_lru #(
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .ages      (age_q[req_idx]),
        .valid     (valid_q[req_idx]),
        .touch_way (touch_way),
        .ages_nxt  (ages_nxt),
        .victim    (victim)
    );

    // Tag match across the ways of the requested set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Single line write port and LRU touch: write hits, direct write installs, fills
    always_comb begin
        data_we   = 1'b0;
        data_way  = hit_way;
        data_wdat = req_data_q;
        lru_touch = 1'b0;
        touch_way = hit_way;
        case (state_q)
            ST_LOOKUP: begin
                if (hit) begin
                    lru_touch = 1'b1;
                    data_we   = req_wr_q;
                end else if (req_wr_q && !vict_dirty) begin
                    data_we   = 1'b1;
                    data_way  = victim;
                    lru_touch = 1'b1;
                    touch_way = victim;
                end
            end
            ST_WRITEBACK: begin
                if (mem_write && mem_ready && req_wr_q) begin
                    data_we   = 1'b1;
                    data_way  = vict_q;
                    lru_touch = 1'b1;
                    touch_way = vict_q;
                end
            end
            ST_FILL: begin
                if (mem_read && mem_ready) begin
                    data_we   = 1'b1;
                    data_way  = vict_q;
                    data_wdat = mem_data_block;
                    lru_touch = 1'b1;
                    touch_way = vict_q;
                end
            end
            default: ;
        endcase
    end

    // Tag and data arrays carry no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[req_idx][data_way] <= data_wdat;
            tag_q[req_idx][data_way]  <= req_tag;
        end
    end

    // Controller, line state bits and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            req_blk_q         <= '0;
            req_data_q        <= '0;
            req_wr_q          <= 1'b0;
            hit_q             <= 1'b0;
            vict_q            <= '0;
            resp_way_q        <= '0;
            fl_set_q          <= '0;
            fl_way_q          <= '0;
            l1_block_data_out <= '0;
            l1_block_valid    <= 1'b0;
            l1_cache_ready    <= 1'b0;
            l1_cache_hit      <= 1'b0;
            flush_done        <= 1'b0;
            mem_addr          <= '0;
            mem_data_out      <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            l1_block_data_out <= '0;
            l1_block_valid    <= 1'b0;
            l1_cache_ready    <= 1'b0;
            l1_cache_hit      <= 1'b0;
            flush_done        <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        fl_set_q <= '0;
                        fl_way_q <= '0;
                        state_q  <= ST_FLUSH;
                    end else if (l1_cache_read || l1_cache_write) begin
                        req_blk_q  <= l1_cache_addr[ADDR_WIDTH-1:OFFSET_W];
                        req_data_q <= l1_cache_data_in;
                        req_wr_q   <= l1_cache_write;
                        state_q    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        hit_q      <= 1'b1;
                        resp_way_q <= hit_way;
                        state_q    <= ST_RESPOND;
                    end else begin
                        hit_q      <= 1'b0;
                        vict_q     <= victim;
                        resp_way_q <= victim;
                        if (vict_dirty) begin
                            state_q <= ST_WRITEBACK;
                        end else if (req_wr_q) begin
                            state_q <= ST_RESPOND;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!mem_write) begin
                        mem_write    <= 1'b1;
                        mem_addr     <= {tag_q[req_idx][vict_q], req_idx, {OFFSET_W{1'b0}}};
                        mem_data_out <= data_q[req_idx][vict_q];
                    end else if (mem_ready) begin
                        mem_write                <= 1'b0;
                        mem_addr                 <= '0;
                        mem_data_out             <= '0;
                        dirty_q[req_idx][vict_q] <= 1'b0;
                        state_q                  <= req_wr_q ? ST_RESPOND : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!mem_read) begin
                        mem_read <= 1'b1;
                        mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                    end else if (mem_ready) begin
                        mem_read <= 1'b0;
                        mem_addr <= '0;
                        state_q  <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    l1_cache_ready <= 1'b1;
                    l1_cache_hit   <= hit_q;
                    if (!req_wr_q) begin
                        l1_block_valid    <= 1'b1;
                        l1_block_data_out <= data_q[req_idx][resp_way_q];
                    end
                    state_q <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (!mem_write && fl_line_dirty) begin
                        mem_write    <= 1'b1;
                        mem_addr     <= {tag_q[fl_set_q][fl_way_q], fl_set_q, {OFFSET_W{1'b0}}};
                        mem_data_out <= data_q[fl_set_q][fl_way_q];
                    end
                    if (mem_write && mem_ready) begin
                        mem_write                    <= 1'b0;
                        mem_addr                     <= '0;
                        mem_data_out                 <= '0;
                        dirty_q[fl_set_q][fl_way_q]  <= 1'b0;
                    end
                    if (fl_adv) begin
                        if (fl_way_q == WAY_W'(NUM_WAYS - 1)) begin
                            fl_way_q <= '0;
                            if (fl_set_q == INDEX_W'(NUM_SETS - 1)) begin
                                flush_done <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                fl_set_q <= fl_set_q + 1'b1;
                            end
                        end else begin
                            fl_way_q <= fl_way_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Installs come last so a write after writeback leaves the line dirty
            if (lru_touch) begin
                age_q[req_idx] <= ages_nxt;
            end
            if (data_we) begin
                valid_q[req_idx][data_way] <= 1'b1;
                dirty_q[req_idx][data_way] <= req_wr_q;
            end
        end
    end

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed scoreboard bench for l2_cache_wb: expectations queued at issue, checked by monitors.
// Latency: hit latency and clean-miss latency are checked where fixed by the memory model delay.
// Backpressure: memory model inserts a programmable wait or stalls indefinitely.
module tb_l2_cache_wb;

    localparam int BLK_W = 1024;
    typedef logic [BLK_W-1:0] blk_t;

    typedef struct {
        bit   is_rd;
        bit   hit;
        blk_t data;
        int   lat;
        int   issue;
    } l1_exp_t;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        blk_t        data;
    } mem_exp_t;

    logic        clk;
    logic        rst_n;
    logic [10:0] l1_cache_addr;
    blk_t        l1_cache_data_in;
    logic        l1_cache_read;
    logic        l1_cache_write;
    blk_t        l1_block_data_out;
    logic        l1_block_valid;
    logic        l1_cache_ready;
    logic        l1_cache_hit;
    logic        flush_req;
    logic        flush_done;
    logic [10:0] mem_addr;
    blk_t        mem_data_out;
    logic        mem_read;
    logic        mem_write;
    blk_t        mem_data_block = '0;
    logic        mem_ready = 1'b0;

    l1_exp_t  exp_l1[$];
    mem_exp_t exp_mem[$];

    int n_vec     = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int resp_cnt  = 0;
    int done_cnt  = 0;
    int mem_lat   = 0;
    bit mem_stall = 0;
    bit mem_busy  = 0;
    int mem_cnt   = 0;

    l2_cache_wb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l1_cache_addr     (l1_cache_addr),
        .l1_cache_data_in  (l1_cache_data_in),
        .l1_cache_read     (l1_cache_read),
        .l1_cache_write    (l1_cache_write),
        .l1_block_data_out (l1_block_data_out),
        .l1_block_valid    (l1_block_valid),
        .l1_cache_ready    (l1_cache_ready),
        .l1_cache_hit      (l1_cache_hit),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .mem_addr          (mem_addr),
        .mem_data_out      (mem_data_out),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_data_block    (mem_data_block),
        .mem_ready         (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic blk_t pat(input logic [15:0] seed);
        blk_t b;
        for (int i = 0; i < 32; i++) begin
            b[i*32 +: 32] = {seed, 16'(i)};
        end
        return b;
    endfunction

    task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // L1 response monitor
    always @(negedge clk) begin
        l1_exp_t e;
        if (rst_n && l1_cache_ready) begin
            if (exp_l1.size() == 0) begin
                chk("unexpected_resp", 1'b0, 128'(l1_cache_hit), 128'd0);
            end else begin
                e = exp_l1.pop_front();
                chk("resp_hit", l1_cache_hit == e.hit, 128'(l1_cache_hit), 128'(e.hit));
                chk("resp_block_valid", l1_block_valid == e.is_rd, 128'(l1_block_valid), 128'(e.is_rd));
                if (e.is_rd)
                    chk("resp_data", l1_block_data_out == e.data, l1_block_data_out[127:0], e.data[127:0]);
                if (e.lat >= 0)
                    chk("resp_latency", (cyc - e.issue) == e.lat, 128'(cyc - e.issue), 128'(e.lat));
            end
            resp_cnt++;
        end
        if (rst_n && flush_done) done_cnt++;
    end

    // Memory model and memory-side checker
    always @(negedge clk) begin
        mem_exp_t m;
        if (!rst_n) begin
            mem_busy  = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                chk("mem_no_overlap", !(mem_read && mem_write), 128'({mem_read, mem_write}), 128'd0);
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem", 1'b0, 128'(mem_addr), 128'd0);
                    mem_data_block = '0;
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_op_is_write", mem_write == m.wr, 128'(mem_write), 128'(m.wr));
                    chk("mem_addr", mem_addr == m.addr, 128'(mem_addr), 128'(m.addr));
                    if (m.wr)
                        chk("mem_wdata", mem_data_out == m.data, mem_data_out[127:0], m.data[127:0]);
                    else
                        mem_data_block = m.data;
                end
            end
            if (!mem_stall) begin
                if (mem_cnt == 0) mem_ready = 1'b1;
                else mem_cnt--;
            end
        end else begin
            if (mem_busy)
                chk("mem_idle_zero", (mem_addr == '0) && (mem_data_out == '0), mem_data_out[127:0] | 128'(mem_addr), 128'd0);
            mem_busy  = 1'b0;
            mem_ready = 1'b0;
        end
    end

    task automatic mem_exp(input bit wr, input logic [10:0] a, input blk_t d);
        mem_exp_t m;
        m.wr = wr; m.addr = a; m.data = d;
        exp_mem.push_back(m);
    endtask

    task automatic l1_op(input bit rd, input bit wr, input logic [10:0] a, input blk_t d,
                         input bit eh, input blk_t ed, input int el);
        l1_exp_t e;
        int start;
        int n;
        @(negedge clk);
        e.is_rd = rd && !wr; e.hit = eh; e.data = ed; e.lat = el; e.issue = cyc + 1;
        exp_l1.push_back(e);
        start            = resp_cnt;
        l1_cache_addr    = a;
        l1_cache_data_in = d;
        l1_cache_read    = rd;
        l1_cache_write   = wr;
        @(negedge clk);
        l1_cache_read    = 1'b0;
        l1_cache_write   = 1'b0;
        l1_cache_addr    = '0;
        l1_cache_data_in = '0;
        n = 0;
        while (resp_cnt == start && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("resp_seen", resp_cnt != start, 128'(resp_cnt - start), 128'd1);
    endtask

    task automatic rd(input logic [10:0] a, input bit eh, input blk_t ed, input int el);
        l1_op(1'b1, 1'b0, a, '0, eh, ed, el);
    endtask

    task automatic wr(input logic [10:0] a, input blk_t d, input bit eh, input int el);
        l1_op(1'b0, 1'b1, a, d, eh, '0, el);
    endtask

    task automatic do_flush();
        int start;
        int n;
        @(negedge clk);
        start     = done_cnt;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n = 0;
        while (done_cnt == start && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("flush_done_seen", done_cnt != start, 128'(done_cnt - start), 128'd1);
        @(negedge clk);
        chk("flush_writes_consumed", exp_mem.size() == 0, 128'(exp_mem.size()), 128'd0);
    endtask

    initial begin
        blk_t a_d, b_d, c1, c2, c3, d_d, e_d, f_d, g_d, h_d, j_d;
        int n;
        a_d = pat(16'hA000); b_d = pat(16'hB000); c1 = pat(16'hC001);
        c2  = pat(16'hC002); c3  = pat(16'hC003); d_d = pat(16'hD000);
        e_d = pat(16'hE000); f_d = pat(16'hF000); g_d = pat(16'h6000);
        h_d = pat(16'h7000); j_d = pat(16'h8000);

        rst_n            = 1'b0;
        l1_cache_addr    = '0;
        l1_cache_data_in = '0;
        l1_cache_read    = 1'b0;
        l1_cache_write   = 1'b0;
        flush_req        = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_strobes", {l1_cache_ready, l1_block_valid, l1_cache_hit, flush_done, mem_read, mem_write} == 6'b0,
            128'({l1_cache_ready, l1_block_valid, l1_cache_hit, flush_done, mem_read, mem_write}), 128'd0);
        chk("reset_mem_bus", (mem_addr == '0) && (mem_data_out == '0), mem_data_out[127:0] | 128'(mem_addr), 128'd0);
        chk("reset_l1_data", l1_block_data_out == '0, l1_block_data_out[127:0], 128'd0);
        rst_n = 1'b1;

        // Cold miss then hits on set 0, tag 0
        mem_lat = 0;
        mem_exp(1'b0, 11'h000, a_d);
        rd(11'h000, 1'b0, a_d, 4);
        rd(11'h000, 1'b1, a_d, 2);
        wr(11'h000, b_d, 1'b1, 2);
        rd(11'h000, 1'b1, b_d, 2);

        // Fill remaining ways of set 0, then evict the LRU clean line
        mem_lat = 3;
        mem_exp(1'b0, 11'h080, c1); rd(11'h080, 1'b0, c1, -1);
        mem_exp(1'b0, 11'h100, c2); rd(11'h100, 1'b0, c2, -1);
        mem_exp(1'b0, 11'h180, c3); rd(11'h180, 1'b0, c3, -1);
        rd(11'h000, 1'b1, b_d, 2);
        mem_exp(1'b0, 11'h200, d_d); rd(11'h200, 1'b0, d_d, -1);

        // Write miss installs 0x080 dirty over clean 0x100; make it LRU
        wr(11'h080, e_d, 1'b0, 2);
        rd(11'h180, 1'b1, c3, 2);
        rd(11'h200, 1'b1, d_d, 2);
        rd(11'h000, 1'b1, b_d, 2);

        // Dirty victim: writeback of 0x080 precedes fill of 0x280
        mem_lat = 2;
        mem_exp(1'b1, 11'h080, e_d);
        mem_exp(1'b0, 11'h280, f_d);
        rd(11'h280, 1'b0, f_d, -1);
        wr(11'h180, g_d, 1'b1, 2);

        // Flush with two dirty lines, then an idle flush
        mem_lat = 1;
        mem_exp(1'b1, 11'h000, b_d);
        mem_exp(1'b1, 11'h180, g_d);
        do_flush();
        do_flush();
        rd(11'h180, 1'b1, g_d, 2);

        // Both strobes high is a write; the miss installs without fetching
        l1_op(1'b1, 1'b1, 11'h020, h_d, 1'b0, '0, 2);
        rd(11'h020, 1'b1, h_d, 2);

        // Reset during a stalled fill
        mem_stall = 1'b1;
        mem_exp(1'b0, 11'h300, j_d);
        @(negedge clk);
        l1_cache_addr = 11'h300;
        l1_cache_read = 1'b1;
        @(negedge clk);
        l1_cache_read = 1'b0;
        l1_cache_addr = '0;
        n = 0;
        while (!mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fill_started", mem_read == 1'b1, 128'(mem_read), 128'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_drop", {mem_read, mem_write} == 2'b00, 128'({mem_read, mem_write}), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        mem_lat   = 0;
        mem_exp(1'b0, 11'h300, j_d);
        rd(11'h300, 1'b0, j_d, 4);
        rd(11'h300, 1'b1, j_d, 2);

        repeat (4) @(negedge clk);
        chk("l1_queue_empty", exp_l1.size() == 0, 128'(exp_l1.size()), 128'd0);
        chk("mem_queue_empty", exp_mem.size() == 0, 128'(exp_mem.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
